lc3_stage_sequencer: RTL and testbench
======================================

LC3_STAGE_SEQUENCER -- requirements
Module: lc3_stage_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 4: stages per instruction, 2..16.
REQ-002 Parameter STAGE_W, default 2: stage index width; SHALL equal clog2(NUM_STAGES).
REQ-003 Parameter CNT_W, default 16: width of the performance counters.
REQ-004 Parameter MAX_WAIT, default 15: longest legal memory wait in cycles, 1..255.
REQ-005 CLK  in  1  single clock; all state on rising edge.
REQ-006 RESET  in  1  asynchronous, active-low reset.
REQ-007 NEXT_STAGE  in  STAGE_W  stage to load when NEXT_STAGE_LE=1.
REQ-008 NEXT_STAGE_LE  in  1  load request from control; otherwise increment.
REQ-009 MEM_REQ  in  1  current stage performs a memory access.
REQ-010 MEM_READY  in  1  memory access completes this cycle.
REQ-011 HALT_REQ  in  1  halt at next instruction boundary (TRAP x25).
REQ-012 STAGE  out  STAGE_W  current stage.
REQ-013 STAGE_VALID  out  1  current stage may commit (PC_LE/IR_LE/RD_LE/MEM_WE gated by it).
REQ-014 INSTR_DONE  out  1  one-cycle pulse on instruction retire.
REQ-015 HALTED  out  1  sequencer stopped.
REQ-016 TIMEOUT  out  1  sticky memory wait overrun flag.
REQ-017 BAD_STAGE  out  1  sticky flag: NEXT_STAGE >= NUM_STAGES was loaded.
REQ-018 INSTR_COUNT  out  CNT_W  retired instructions.
REQ-019 CYCLE_COUNT  out  CNT_W  non-halted cycles.

Function
REQ-020 FSM states: RUN, WAIT, STOP.
REQ-021 Advance event: RUN with !(MEM_REQ & !MEM_READY), or WAIT with MEM_READY=1.
REQ-022 On advance, if NEXT_STAGE_LE=1 and NEXT_STAGE < NUM_STAGES, STAGE <= NEXT_STAGE.
REQ-023 On advance, if NEXT_STAGE_LE=1 and NEXT_STAGE >= NUM_STAGES, STAGE <= 0 and BAD_STAGE <= 1.
REQ-024 On advance, if NEXT_STAGE_LE=0, STAGE <= STAGE+1; from NUM_STAGES-1 it wraps to 0.
REQ-025 Retire: an advance whose new STAGE is 0; INSTR_DONE=1 in the following cycle only.
REQ-026 RUN with MEM_REQ=1, MEM_READY=0: go to WAIT; STAGE holds; wait counter <= 1.
REQ-027 WAIT with MEM_READY=0: STAGE holds; wait counter increments.
REQ-028 WAIT with MEM_READY=0 and wait counter = MAX_WAIT: TIMEOUT <= 1; go to STOP.
REQ-029 WAIT with MEM_READY=1: advance per REQ-022..024; go to RUN.
REQ-030 STAGE_VALID = (state != STOP) & !(MEM_REQ & !MEM_READY); combinational, no added latency.
REQ-031 HALT_REQ is latched into a pending flag whenever asserted; the flag clears only on reset.
REQ-032 Retire with the pending flag set (including HALT_REQ in the same cycle): go to STOP with STAGE=0.
REQ-033 In STOP: STAGE, counters and flags hold, STAGE_VALID=0, HALTED=1; exit only by reset.
REQ-034 CYCLE_COUNT increments every cycle not in STOP.
REQ-035 INSTR_COUNT increments on each retire.
REQ-036 Both counters saturate at all-ones and never wrap.
REQ-037 Simultaneous retire and timeout cannot occur; timeout takes priority over a pending halt.

Reset
REQ-038 RESET low asynchronously forces STAGE=0, state RUN, INSTR_DONE=0, HALTED=0, TIMEOUT=0, BAD_STAGE=0, both counters 0, wait counter 0, halt pending 0.
REQ-039 Reset asserted mid-WAIT or in STOP abandons the operation; the first rising edge after release evaluates stage 0 in RUN.

Structure
REQ-040 lc3_pkg SHALL hold the FSM state enum (RUN/WAIT/STOP) and the default parameter constants.
REQ-041 One sub-module, lc3_sat_counter (parametrised width, enable, saturating), SHALL be instantiated for INSTR_COUNT and CYCLE_COUNT.
REQ-042 The block SHALL replace the fixed 2-bit stage counter at the LC3 top level with no change to control's NEXT_STAGE/NEXT_STAGE_LE protocol.

Verification
REQ-043 Default parameters; 8 cycles with MEM_REQ=0 and NEXT_STAGE_LE=0 -> STAGE 0,1,2,3,0,1,2,3; INSTR_DONE pulses twice; INSTR_COUNT=2; CYCLE_COUNT=8.
REQ-044 At stage 1, MEM_REQ=1 with MEM_READY low for 3 cycles then high -> STAGE stays 1 for 4 cycles; STAGE_VALID=0 for 3 cycles; STAGE=2 next cycle.
REQ-045 MAX_WAIT=4; MEM_REQ=1, MEM_READY=0 held -> TIMEOUT=1 and HALTED=1 after 4 wait cycles; STAGE frozen.
REQ-046 HALT_REQ pulsed at stage 1 -> STAGE=0 after retire; HALTED=1; INSTR_COUNT +1; counters then frozen.
REQ-047 NUM_STAGES=3; NEXT_STAGE_LE=1 with NEXT_STAGE=3 -> STAGE=0, BAD_STAGE=1, INSTR_DONE pulse.
REQ-048 RESET low for 1 cycle mid-WAIT with CNT_W=4 and INSTR_COUNT saturated at 15 -> all outputs cleared per REQ-038; resumes at stage 0.

Source files
------------

// File: rtl/lc3_pkg.sv
// lc3_pkg: sequencer FSM states and default parameter constants.
package lc3_pkg;
  typedef enum logic [1:0] {RUN, WAIT, STOP} seq_state_e;
  localparam int NUM_STAGES_D = 4;
  localparam int STAGE_W_D    = 2;
  localparam int CNT_W_D      = 16;
  localparam int MAX_WAIT_D   = 15;
endpackage

// File: rtl/lc3_sat_counter.sv
// lc3_sat_counter: enabled up-counter that sticks at all-ones.
module lc3_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en && q != '1) q <= q + 1'b1;
endmodule

// File: rtl/lc3_stage_sequencer.sv
// lc3_stage_sequencer: LC3 instruction stage sequencer with memory-wait stall, halt and perf counters.
module lc3_stage_sequencer
  import lc3_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_D,
  parameter int STAGE_W    = STAGE_W_D,
  parameter int CNT_W      = CNT_W_D,
  parameter int MAX_WAIT   = MAX_WAIT_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [STAGE_W-1:0] next_stage,
  input  logic               next_stage_le,
  input  logic               mem_req,
  input  logic               mem_ready,
  input  logic               halt_req,
  output logic [STAGE_W-1:0] stage,
  output logic               stage_valid,
  output logic               instr_done,
  output logic               halted,
  output logic               timeout,
  output logic               bad_stage,
  output logic [CNT_W-1:0]   instr_count,
  output logic [CNT_W-1:0]   cycle_count
);
  localparam logic [STAGE_W:0]   N_EXT    = (STAGE_W+1)'(NUM_STAGES);
  localparam logic [STAGE_W-1:0] LAST     = STAGE_W'(NUM_STAGES - 1);
  localparam logic [7:0]         WAIT_MAX = 8'(MAX_WAIT);
  seq_state_e         state, state_n;
  logic [STAGE_W-1:0] stage_n, tgt;
  logic [7:0]         wait_cnt, wait_n;
  logic               halt_pend, halt_now, stall, adv, bad_ld, retire, timeout_n, bad_n;
  always_comb begin
    stall     = mem_req & ~mem_ready;
    adv       = (state == RUN & ~stall) | (state == WAIT & mem_ready);
    bad_ld    = next_stage_le & ({1'b0, next_stage} >= N_EXT);
    tgt       = next_stage_le ? (bad_ld ? '0 : next_stage) : (stage == LAST ? '0 : stage + 1'b1);
    retire    = adv & (tgt == '0);
    halt_now  = halt_pend | halt_req;
    state_n   = state;
    stage_n   = stage;
    wait_n    = wait_cnt;
    timeout_n = timeout;
    bad_n     = bad_stage;
    if (adv) begin
      stage_n = tgt;
      bad_n   = bad_stage | bad_ld;
      state_n = (retire & halt_now) ? STOP : RUN;
    end else if (state == RUN) begin
      state_n = WAIT;
      wait_n  = 8'd1;
    end else if (state == WAIT) begin
      // timeout wins over any pending halt since no retire happens here
      timeout_n = wait_cnt == WAIT_MAX;
      state_n   = timeout_n ? STOP : WAIT;
      wait_n    = timeout_n ? wait_cnt : wait_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= RUN;
      stage      <= '0;
      wait_cnt   <= '0;
      halt_pend  <= 1'b0;
      instr_done <= 1'b0;
      timeout    <= 1'b0;
      bad_stage  <= 1'b0;
    end else begin
      state      <= state_n;
      stage      <= stage_n;
      wait_cnt   <= wait_n;
      halt_pend  <= halt_now;
      instr_done <= retire;
      timeout    <= timeout_n;
      bad_stage  <= bad_n;
    end
  assign halted      = state == STOP;
  assign stage_valid = ~halted & ~stall;
  lc3_sat_counter #(.W(CNT_W)) u_instr_cnt (.clk(clk), .rst_n(rst_n), .en(retire), .q(instr_count));
  lc3_sat_counter #(.W(CNT_W)) u_cycle_cnt (.clk(clk), .rst_n(rst_n), .en(~halted), .q(cycle_count));
endmodule

// File: tb/tb_lc3_stage_sequencer.sv
// tb_lc3_stage_sequencer: vector table, directed corner sequences and random stimulus against a reference model.
module tb_lc3_stage_sequencer;
  localparam int N = 3, SW = 2, CW = 4, MW = 4, CMAX = 15;
  logic clk = 0, rst_n = 0;
  logic [SW-1:0] next_stage = '0;
  logic next_stage_le = 0, mem_req = 0, mem_ready = 0, halt_req = 0;
  logic [SW-1:0] stage;
  logic stage_valid, instr_done, halted, timeout, bad_stage;
  logic [CW-1:0] instr_count, cycle_count;
  lc3_stage_sequencer #(.NUM_STAGES(N), .STAGE_W(SW), .CNT_W(CW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .next_stage(next_stage), .next_stage_le(next_stage_le),
    .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .stage(stage),
    .stage_valid(stage_valid), .instr_done(instr_done), .halted(halted), .timeout(timeout),
    .bad_stage(bad_stage), .instr_count(instr_count), .cycle_count(cycle_count));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int m_stage, m_mode, m_wcnt, m_pend, m_done, m_to, m_bad, m_ic, m_cc;
  typedef struct {
    int ns; logic le, rq, rd, h;
    int e_stage; logic e_valid, e_done, e_bad;
  } vec_t;
  vec_t tbl [11];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void model_reset();
    {m_stage, m_mode, m_wcnt, m_pend, m_done, m_to, m_bad, m_ic, m_cc} = '0;
  endfunction
  // mode: 0 running, 1 waiting on memory, 2 stopped
  function automatic void model_step();
    int tgt;
    bit stall, adv, pend_now;
    m_done = 0;
    if (m_mode == 2) return;
    m_cc = (m_cc < CMAX) ? m_cc + 1 : m_cc;
    stall = mem_req && !mem_ready;
    pend_now = m_pend != 0 || halt_req;
    adv = (m_mode == 0) ? !stall : mem_ready;
    if (adv) begin
      if (next_stage_le) begin
        tgt = (int'(next_stage) >= N) ? 0 : int'(next_stage);
        if (int'(next_stage) >= N) m_bad = 1;
      end else tgt = (m_stage + 1) % N;
      m_stage = tgt;
      m_mode = 0;
      if (tgt == 0) begin
        m_done = 1;
        m_ic = (m_ic < CMAX) ? m_ic + 1 : m_ic;
        if (pend_now) m_mode = 2;
      end
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_wcnt = 1;
    end else if (m_wcnt == MW) begin
      m_to = 1;
      m_mode = 2;
    end else m_wcnt++;
    m_pend = pend_now;
  endfunction
  task automatic check_all();
    chk("stage", int'(stage), m_stage);
    chk("instr_done", int'(instr_done), m_done);
    chk("halted", int'(halted), int'(m_mode == 2));
    chk("timeout", int'(timeout), m_to);
    chk("bad_stage", int'(bad_stage), m_bad);
    chk("instr_count", int'(instr_count), m_ic);
    chk("cycle_count", int'(cycle_count), m_cc);
  endtask
  task automatic tick();
    #1 chk("stage_valid", int'(stage_valid), int'(m_mode != 2 && !(mem_req && !mem_ready)));
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask
  task automatic do_reset();
    rst_n = 0;
    #1 model_reset();
    check_all();
    chk("rst_valid_hi", int'(stage_valid), int'(!(mem_req && !mem_ready)));
    @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic drive(input int ns, input logic le, input logic rq, input logic rd, input logic h);
    next_stage = SW'(ns);
    next_stage_le = le;
    mem_req = rq;
    mem_ready = rd;
    halt_req = h;
  endtask
  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 2, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 1, 0, 2, 1, 0, 0};
    tbl[8]  = '{3, 1, 0, 0, 0, 0, 1, 1, 1};
    tbl[9]  = '{2, 1, 0, 0, 0, 2, 1, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].ns, tbl[i].le, tbl[i].rq, tbl[i].rd, tbl[i].h);
      #1 chk($sformatf("tbl%0d_valid", i), int'(stage_valid), int'(tbl[i].e_valid));
      tick();
      chk($sformatf("tbl%0d_stage", i), int'(stage), tbl[i].e_stage);
      chk($sformatf("tbl%0d_done", i), int'(instr_done), int'(tbl[i].e_done));
      chk($sformatf("tbl%0d_bad", i), int'(bad_stage), int'(tbl[i].e_bad));
    end
    chk("tbl_instr_count", int'(instr_count), 3);
    chk("tbl_cycle_count", int'(cycle_count), 11);
    // memory wait overrun
    do_reset();
    drive(0, 0, 1, 0, 0);
    repeat (4) tick();
    chk("to_not_yet", int'(halted), 0);
    tick();
    chk("to_timeout", int'(timeout), 1);
    chk("to_halted", int'(halted), 1);
    repeat (3) tick();
    chk("to_stage_frozen", int'(stage), 0);
    chk("to_cycles_frozen", int'(cycle_count), 5);
    // halt request at stage 1
    do_reset();
    drive(0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    chk("halt_halted", int'(halted), 1);
    chk("halt_stage", int'(stage), 0);
    chk("halt_instr_count", int'(instr_count), 1);
    chk("halt_done", int'(instr_done), 1);
    repeat (3) tick();
    chk("halt_done_clear", int'(instr_done), 0);
    chk("halt_cycles_frozen", int'(cycle_count), 3);
    // reset mid-wait with saturated counters
    do_reset();
    repeat (50) tick();
    chk("sat_instr_count", int'(instr_count), 15);
    drive(0, 0, 1, 0, 0);
    repeat (2) tick();
    do_reset();
    chk("rst_instr_count", int'(instr_count), 0);
    chk("rst_stage", int'(stage), 0);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("rst_resume_stage", int'(stage), 1);
    chk("rst_resume_cycles", int'(cycle_count), 1);
    // random
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0 || (halted && $urandom_range(7) == 0)) do_reset();
      else begin
        drive(int'($urandom_range(3)), $urandom_range(3) == 0, $urandom_range(9) < 3,
              $urandom_range(1) == 1, $urandom_range(39) == 0);
        tick();
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
